// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter; watchdog enabled by PS2_TX_TIMEOUT_EN
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int RTS_CYCLES = 200,
  parameter int FILTER_MAX = 19
`ifdef PS2_TX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 2000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       wen,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int FW = $clog2(FILTER_MAX + 2);
  localparam int TW = $clog2((INHIBIT_CYCLES > RTS_CYCLES ? INHIBIT_CYCLES : RTS_CYCLES) + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_MAX);
  localparam logic [TW-1:0] INH_END = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] RTS_END = TW'(RTS_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic [1:0] s1, s2, f;
  logic [FW-1:0] fc [2];
  logic f_clk_d, fall, expire;
  logic [TW-1:0] tmr, tmr_n;
  logic [3:0] bitcnt, bitcnt_n;
  logic [7:0] byte_q, byte_n;
  logic par, par_n, dq, dq_n, err_n, done_n;
  // bit 0 is the clock line, bit 1 the data line; a new level is taken only after FILTER_MAX+1 stable cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
      f <= '1;
      f_clk_d <= 1'b1;
      fc[0] <= '0;
      fc[1] <= '0;
    end else begin
      s1 <= {ps2_data, ps2_clk};
      s2 <= s1;
      f_clk_d <= f[0];
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == f[i]) fc[i] <= '0;
        else if (fc[i] == FMAX) begin
          f[i] <= s2[i];
          fc[i] <= '0;
        end else fc[i] <= fc[i] + 1'b1;
      end
    end
  end
  assign fall = f_clk_d & ~f[0];
`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_END = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wd;
  // per-transfer watchdog, held at zero while idle so it restarts on every accepted send
  always_ff @(posedge clk) wd <= (rst || state == IDLE) ? '0 : wd + 1'b1;
  assign expire = state != IDLE && wd == WD_END;
`else
  assign expire = 1'b0;
`endif
  // next-state: inhibit, request-to-send, device-clocked bits, ack check, wait for idle lines
  always_comb begin
    state_n = state;
    tmr_n = tmr + 1'b1;
    bitcnt_n = bitcnt;
    byte_n = byte_q;
    par_n = par;
    dq_n = dq;
    err_n = err;
    done_n = 1'b0;
    case (state)
      IDLE: if (wen) begin
        state_n = INHIBIT;
        tmr_n = '0;
        byte_n = wdata;
        par_n = ~^wdata;
        err_n = 1'b0;
        dq_n = 1'b0;
      end
      INHIBIT: if (tmr == INH_END) begin
        state_n = RTS;
        tmr_n = '0;
        dq_n = 1'b1;
      end
      RTS: if (tmr == RTS_END) begin
        state_n = SEND;
        bitcnt_n = '0;
      end
      SEND: if (fall) begin
        bitcnt_n = bitcnt + 1'b1;
        dq_n = bitcnt < 4'd8 ? ~byte_q[bitcnt[2:0]] : bitcnt == 4'd8 ? ~par : 1'b0;
        state_n = bitcnt == 4'd9 ? ACK : SEND;
      end
      ACK: if (fall) begin
        state_n = f[1] ? IDLE : WAIT_IDLE;
        err_n = f[1];
      end
      WAIT_IDLE: if (f[0] && f[1]) begin
        state_n = IDLE;
        done_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (expire) begin
      state_n = IDLE;
      dq_n = 1'b0;
      err_n = 1'b1;
      done_n = 1'b0;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tmr <= '0;
      bitcnt <= '0;
      byte_q <= '0;
      par <= 1'b0;
      dq <= 1'b0;
      err <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      tmr <= tmr_n;
      bitcnt <= bitcnt_n;
      byte_q <= byte_n;
      par <= par_n;
      dq <= dq_n;
      err <= err_n;
      done <= done_n;
    end
  end
  assign ps2_clk_oe = state == INHIBIT || state == RTS;
  assign ps2_data_oe = dq;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized PS/2 host transmit bench with a behavioural keyboard model
module tb_ps2_host_tx;
  localparam int INH = 40, RTS = 12, FM = 3, TO = 700, H = 20;
  logic clk = 0, rst = 1, wen = 0;
  logic [7:0] wdata = 0;
  logic dev_clk_low = 0, dev_data_low = 0;
  logic ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe, busy, done, err;
  int checks = 0, errors = 0, done_cnt = 0;
  assign ps2_clk = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe | dev_data_low);
  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES(RTS),
    .FILTER_MAX(FM)
`ifdef PS2_TX_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .wen(wen),
    .wdata(wdata),
    .busy(busy),
    .done(done),
    .err(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;
  initial begin
    #5ms;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // line bits in time order: start 0, data LSB first, odd parity, stop 1
  function automatic logic [31:0] frame(input logic [7:0] b);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 8; i++) r[i + 1] = (b >> i) & 1;
    r[9] = ($countones(b) % 2) == 0;
    r[10] = 1;
    return r;
  endfunction
  task automatic start(input logic [7:0] b, input bit extra);
    int n_inh, n_rts;
    n_inh = 0;
    n_rts = 0;
    @(negedge clk);
    wen = 1;
    wdata = b;
    @(negedge clk);
    wen = 0;
    wdata = 8'($urandom);
    check("accept_busy", 32'(busy), 1);
    check("accept_clk_oe", 32'(ps2_clk_oe), 1);
    check("accept_err_clear", 32'(err), 0);
    for (int i = 0; i < INH + RTS + 50 && ps2_clk_oe; i++) begin
      if (ps2_data_oe) n_rts++;
      else n_inh++;
      if (extra && i == INH / 2) begin
        wen = 1;
        wdata = 8'h55;
      end else wen = 0;
      @(negedge clk);
    end
    wen = 0;
    check("inhibit_len", n_inh, INH);
    check("rts_len", n_rts, RTS);
    check("start_bit_held", 32'(ps2_data_oe), 1);
  endtask
  task automatic device(input bit ack, output logic [31:0] got);
    got = 0;
    repeat (2 * H) @(negedge clk);
    got[0] = ps2_data;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1;
      repeat (H) @(negedge clk);
      if (k <= 10) got[k] = ps2_data;
      dev_clk_low = 0;
      repeat (H / 2) @(negedge clk);
      if (k == 10) dev_data_low = ack;
      if (k == 11) dev_data_low = 0;
      repeat (H / 2) @(negedge clk);
    end
  endtask
  task automatic xfer(input logic [7:0] b, input bit ack, input bit extra);
    logic [31:0] got;
    int d0;
    start(b, extra);
    d0 = done_cnt;
    device(ack, got);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    check($sformatf("frame_%02h", b), got, frame(b));
    check("done_pulses", done_cnt - d0, ack ? 1 : 0);
    check("err_after", 32'(err), ack ? 0 : 1);
    check("busy_end", 32'(busy), 0);
    check("oe_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
  endtask
  initial begin
    int d0, n;
    repeat (3) @(negedge clk);
    check("rst_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, busy, done, err}, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    xfer(8'hED, 1, 0);
    xfer(8'hF4, 1, 0);
    xfer(8'h00, 1, 0);
    xfer(8'hA5, 0, 0);
    repeat (5) @(negedge clk);
    check("err_sticky", 32'(err), 1);
    xfer(8'h3C, 1, 1);
    repeat (6) xfer(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
    start(8'h96, 0);
    d0 = done_cnt;
    repeat (H) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_mid_busy_err", {30'd0, busy, err}, 0);
    check("rst_mid_done", done_cnt - d0, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    start(8'h11, 0);
    d0 = done_cnt;
`ifdef PS2_TX_TIMEOUT_EN
    n = INH + RTS;
    while (busy && n < TO + 100) begin
      n++;
      @(negedge clk);
    end
    check("timeout_busy_len", n, TO);
    check("timeout_err", 32'(err), 1);
    check("timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    check("timeout_no_done", done_cnt - d0, 0);
`else
    n = 0;
    repeat (TO) @(negedge clk);
    check("silent_busy", 32'(busy), 1);
    check("silent_err", 32'(err), 0);
    check("silent_no_done", done_cnt - d0, n);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("silent_rst_busy", 32'(busy), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
